// File: rtl/cache_mem_arbiter_pkg.sv
// Memory message types shared by the caches, the arbiter and the memory port.
// Field layout follows the 16B request/response messages of the memory system.
package cache_mem_arbiter_pkg;

   typedef struct packed {
      logic [2:0]   type_;
      logic [7:0]   opaque;
      logic [31:0]  addr;
      logic [3:0]   len;
      logic [127:0] data;
   } mem_req_16B_t;

   typedef struct packed {
      logic [2:0]   type_;
      logic [7:0]   opaque;
      logic [1:0]   test;
      logic [3:0]   len;
      logic [127:0] data;
   } mem_resp_16B_t;

endpackage

// File: rtl/cache_mem_arbiter_id_fifo.sv
// Small FIFO of 1-bit requester IDs that records the order memory requests
// were issued, so in-order memory responses can be routed back.
module cache_mem_arbiter_id_fifo #(
   parameter int p_depth = 2,
   localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1,
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enq_val,
   input  logic          enq_id,
   input  logic          deq_val,
   output logic          deq_id,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [p_depth-1:0] entries_q, entries_d;
   logic [PW-1:0]      wptr_q, wptr_d;
   logic [PW-1:0]      rptr_q, rptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               do_enq;
   logic               do_deq;

   assign full   = (count_q == CW'(p_depth));
   assign empty  = (count_q == '0);
   assign count  = count_q;
   assign deq_id = entries_q[rptr_q];

   always_comb begin
      entries_d = entries_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      do_enq    = enq_val && !full;
      do_deq    = deq_val && !empty;
      if (do_enq) begin
         entries_d[wptr_q] = enq_id;
         wptr_d = (wptr_q == PW'(p_depth - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (do_deq) begin
         rptr_d = (rptr_q == PW'(p_depth - 1)) ? '0 : rptr_q + PW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_enq, do_deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         entries_q <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
      end else begin
         entries_q <= entries_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one 16B memory port between the instruction cache (port 0) and the
// data cache (port 1): round-robin arbitration with grant lock, in-order return.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int p_max_outst = 2,
   localparam int CW = ((p_max_outst > 1) ? $clog2(p_max_outst) : 1) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  mem_req_16B_t  req0_msg,
   input  logic          req0_val,
   output logic          req0_rdy,
   input  mem_req_16B_t  req1_msg,
   input  logic          req1_val,
   output logic          req1_rdy,
   output mem_resp_16B_t resp0_msg,
   output logic          resp0_val,
   input  logic          resp0_rdy,
   output mem_resp_16B_t resp1_msg,
   output logic          resp1_val,
   input  logic          resp1_rdy,
   output mem_req_16B_t  memreq_msg,
   output logic          memreq_val,
   input  logic          memreq_rdy,
   input  mem_resp_16B_t memresp_msg,
   input  logic          memresp_val,
   output logic          memresp_rdy,
   output logic          trace_grant,
   output logic [CW-1:0] trace_count,
   output logic          trace_head,
   output logic          trace_lock
);

   // Every channel uses val/rdy: a message moves on a rising edge where val
   // and rdy are both high; a sender holding val keeps its msg stable.

   logic prio_q, prio_d;
   logic lock_q, lock_d;
   logic locked_id_q, locked_id_d;
   logic grant;
   logic granted_val;
   logic xfer;
   logic fifo_full;
   logic fifo_empty;
   logic fifo_head;
   logic resp_head_val;
   logic pop;

   always_comb begin
      grant = 1'b0;
      if (lock_q) begin
         grant = locked_id_q;
      end else if (req0_val && req1_val) begin
         grant = prio_q;
      end else if (req1_val) begin
         grant = 1'b1;
      end

      granted_val = grant ? req1_val : req0_val;
      memreq_msg  = grant ? req1_msg : req0_msg;
      // Reset gates the outgoing valid even while a cache still drives val.
      memreq_val  = granted_val && !fifo_full && reset;
      req0_rdy    = !grant && memreq_rdy && !fifo_full;
      req1_rdy    = grant && memreq_rdy && !fifo_full;
      xfer        = memreq_val && memreq_rdy;

      prio_d      = prio_q;
      lock_d      = lock_q;
      locked_id_d = locked_id_q;
      if (xfer) begin
         prio_d = ~grant;
         lock_d = 1'b0;
      end else if (memreq_val) begin
         lock_d      = 1'b1;
         locked_id_d = grant;
      end
   end

   always_comb begin
      resp_head_val = memresp_val && !fifo_empty;
      resp0_val     = resp_head_val && !fifo_head;
      resp1_val     = resp_head_val && fifo_head;
      resp0_msg     = memresp_msg;
      resp1_msg     = memresp_msg;
      memresp_rdy   = (fifo_head ? resp1_rdy : resp0_rdy) && !fifo_empty;
      pop           = memresp_val && memresp_rdy;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio_q      <= 1'b0;
         lock_q      <= 1'b0;
         locked_id_q <= 1'b0;
      end else begin
         prio_q      <= prio_d;
         lock_q      <= lock_d;
         locked_id_q <= locked_id_d;
      end
   end

   cache_mem_arbiter_id_fifo #(.p_depth(p_max_outst)) u_id_fifo (
      .clk     (clk),
      .reset   (reset),
      .enq_val (xfer),
      .enq_id  (grant),
      .deq_val (pop),
      .deq_id  (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (trace_count)
   );

   assign trace_grant = grant;
   assign trace_head  = fifo_head;
   assign trace_lock  = lock_q;

`ifndef SYNTHESIS
   // A memory response with nothing outstanding means the environment broke protocol.
   resp_without_request: assert property (@(posedge clk) disable iff (!reset)
      !(memresp_val && fifo_empty));
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed steps for arbitration, lock, routing
// and reset, then randomized traffic against a per-port in-order reference.
module tb_cache_mem_arbiter;
   import cache_mem_arbiter_pkg::*;

   localparam int N_TXN = 1000;
   localparam int MAX_CYC = 60000;

   logic          clk;
   logic          reset;
   mem_req_16B_t  req0_msg, req1_msg, memreq_msg;
   logic          req0_val, req0_rdy, req1_val, req1_rdy;
   mem_resp_16B_t resp0_msg, resp1_msg, memresp_msg;
   logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;
   logic          memreq_val, memreq_rdy, memresp_val, memresp_rdy;
   logic          trace_grant, trace_head, trace_lock;
   logic [1:0]    trace_count;

   int checks = 0;
   int failures = 0;

   // scoreboard: expected responses per cache, in that cache's issue order
   logic [144:0] exp_q0[$];
   logic [144:0] exp_q1[$];
   // memory model: accepted-request answers and the cycle each may return
   logic [144:0] mem_q[$];
   int           mem_t[$];

   cache_mem_arbiter #(.p_max_outst(2)) dut (
      .clk(clk), .reset(reset),
      .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
      .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
      .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
      .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
      .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
      .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
      .trace_grant(trace_grant), .trace_count(trace_count),
      .trace_head(trace_head), .trace_lock(trace_lock)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic mem_req_16B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] addr, input logic [127:0] data);
      mem_req_16B_t r;
      r.type_  = t;
      r.opaque = op;
      r.addr   = addr;
      r.len    = 4'd0;
      r.data   = data;
      return r;
   endfunction

   // reference memory: the answer is derived from the request contents
   function automatic mem_resp_16B_t mem_answer(input mem_req_16B_t r);
      mem_resp_16B_t a;
      a.type_  = r.type_;
      a.opaque = r.opaque;
      a.test   = 2'd0;
      a.len    = r.len;
      a.data   = r.data ^ {4{r.addr}};
      return a;
   endfunction

   // driver tasks
   task automatic drive_idle();
      req0_val    = 1'b0;
      req1_val    = 1'b0;
      req0_msg    = '0;
      req1_msg    = '0;
      resp0_rdy   = 1'b0;
      resp1_rdy   = 1'b0;
      memreq_rdy  = 1'b1;
      memresp_val = 1'b0;
      memresp_msg = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      drive_idle();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic accept_one(input logic port, input mem_req_16B_t m, input string tag);
      @(negedge clk);
      drive_idle();
      if (port) begin
         req1_val = 1'b1;
         req1_msg = m;
      end else begin
         req0_val = 1'b1;
         req0_msg = m;
      end
      #1;
      check({tag, "_memreq_msg"}, memreq_msg, m);
      check({tag, "_rdy"}, port ? req1_rdy : req0_rdy, 1'b1);
   endtask

   task automatic drain_one(input logic port, input mem_resp_16B_t m, input string tag);
      @(negedge clk);
      drive_idle();
      memresp_val = 1'b1;
      memresp_msg = m;
      resp0_rdy   = 1'b1;
      resp1_rdy   = 1'b1;
      #1;
      check({tag, "_resp0_val"}, resp0_val, !port);
      check({tag, "_resp1_val"}, resp1_val, port);
      check({tag, "_resp_msg"}, port ? resp1_msg : resp0_msg, m);
      check({tag, "_memresp_rdy"}, memresp_rdy, 1'b1);
   endtask

   mem_req_16B_t  ra, rb, rc, rd;
   mem_resp_16B_t ma, mb;
   logic          pv[2];
   mem_req_16B_t  pm[2];
   int            n_gen[2];
   int            n_done[2];
   int            cyc;
   int            t_ready;
   logic          acc0, acc1, xfer, r0, r1, mh;

   initial begin
      // ---- reset state ----
      reset = 1'b0;
      drive_idle();
      #2;
      check("rst_memreq_val", memreq_val, 1'b0);
      check("rst_resp0_val", resp0_val, 1'b0);
      check("rst_resp1_val", resp1_val, 1'b0);
      check("rst_memresp_rdy", memresp_rdy, 1'b0);
      check("rst_req0_rdy", req0_rdy, 1'b1);
      check("rst_count", trace_count, 2'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("post_rst_memreq_val", memreq_val, 1'b0);
      check("post_rst_memresp_rdy", memresp_rdy, 1'b0);

      // ---- single requester ----
      ra = mk_req(3'd0, 8'h11, 32'h0000_1000, 128'h0);
      accept_one(1'b0, ra, "single");
      check("single_memreq_val", memreq_val, 1'b1);
      check("single_req1_rdy", req1_rdy, 1'b0);
      ma = '0;
      ma.opaque = 8'h11;
      ma.data   = 128'hdeadbeef_0123_4567_89ab_cdef_cafe_f00d;
      drain_one(1'b0, ma, "single_resp");
      check("single_count_before_pop", trace_count, 2'd1);
      @(negedge clk);
      drive_idle();
      #1;
      check("single_count_after", trace_count, 2'd0);

      // ---- contention: grants 0 then 1, then the FIFO fills ----
      apply_reset();
      ra = mk_req(3'd0, 8'h20, 32'h0000_2000, 128'ha0);
      rb = mk_req(3'd1, 8'h21, 32'h0000_3000, 128'hb0);
      rc = mk_req(3'd0, 8'h22, 32'h0000_2010, 128'ha1);
      @(negedge clk);
      req0_val = 1'b1; req0_msg = ra; req1_val = 1'b1; req1_msg = rb;
      #1;
      check("cont_g0_msg", memreq_msg, ra);
      check("cont_g0_rdy0", req0_rdy, 1'b1);
      check("cont_g0_rdy1", req1_rdy, 1'b0);
      @(negedge clk);
      req0_msg = rc;
      #1;
      check("cont_g1_msg", memreq_msg, rb);
      check("cont_g1_rdy1", req1_rdy, 1'b1);
      check("cont_g1_rdy0", req0_rdy, 1'b0);
      @(negedge clk);
      req1_msg = rc;
      #1;
      check("cont_full_val", memreq_val, 1'b0);
      check("cont_full_rdy0", req0_rdy, 1'b0);
      check("cont_full_rdy1", req1_rdy, 1'b0);
      check("cont_full_count", trace_count, 2'd2);
      drain_one(1'b0, mem_answer(ra), "cont_drain0");
      drain_one(1'b1, mem_answer(rb), "cont_drain1");

      // ---- stall lock: port 1 favoured, yet port 0 keeps the grant ----
      apply_reset();
      accept_one(1'b0, mk_req(3'd0, 8'h30, 32'h40, 128'h1), "lock_warm");
      drain_one(1'b0, mem_answer(mk_req(3'd0, 8'h30, 32'h40, 128'h1)), "lock_warm_resp");
      ra = mk_req(3'd0, 8'h31, 32'h0000_5000, 128'h55);
      rb = mk_req(3'd1, 8'h32, 32'h0000_6000, 128'h66);
      @(negedge clk);
      drive_idle();
      memreq_rdy = 1'b0;
      req0_val = 1'b1; req0_msg = ra;
      #1;
      check("lock_c1_msg", memreq_msg, ra);
      check("lock_c1_val", memreq_val, 1'b1);
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk);
         req1_val = 1'b1; req1_msg = rb;
         #1;
         check($sformatf("lock_c%0d_msg", c), memreq_msg, ra);
         check($sformatf("lock_c%0d_lock", c), trace_lock, 1'b1);
         check($sformatf("lock_c%0d_rdy1", c), req1_rdy, 1'b0);
      end
      @(negedge clk);
      memreq_rdy = 1'b1;
      #1;
      check("lock_c4_msg", memreq_msg, ra);
      check("lock_c4_rdy0", req0_rdy, 1'b1);
      @(negedge clk);
      req0_val = 1'b0;
      #1;
      check("lock_c5_msg", memreq_msg, rb);
      check("lock_c5_rdy1", req1_rdy, 1'b1);
      check("lock_c5_lock", trace_lock, 1'b0);
      drain_one(1'b0, mem_answer(ra), "lock_drain0");
      drain_one(1'b1, mem_answer(rb), "lock_drain1");

      // ---- in-order return with a stalled cache ----
      apply_reset();
      rb = mk_req(3'd1, 8'h41, 32'h0000_7000, 128'h77);
      ra = mk_req(3'd0, 8'h40, 32'h0000_8000, 128'h88);
      accept_one(1'b1, rb, "order_w");
      accept_one(1'b0, ra, "order_r");
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         drive_idle();
         memresp_val = 1'b1;
         memresp_msg = mem_answer(rb);
         resp0_rdy   = 1'b1;
         #1;
         check($sformatf("order_hold%0d_resp1_val", c), resp1_val, 1'b1);
         check($sformatf("order_hold%0d_resp0_val", c), resp0_val, 1'b0);
         check($sformatf("order_hold%0d_memresp_rdy", c), memresp_rdy, 1'b0);
         check($sformatf("order_hold%0d_count", c), trace_count, 2'd2);
      end
      drain_one(1'b1, mem_answer(rb), "order_first");
      drain_one(1'b0, mem_answer(ra), "order_second");

      // ---- asynchronous reset with two transactions in flight ----
      apply_reset();
      rc = mk_req(3'd0, 8'h50, 32'h0000_9000, 128'h99);
      rd = mk_req(3'd1, 8'h51, 32'h0000_a000, 128'haa);
      accept_one(1'b1, mk_req(3'd1, 8'h52, 32'hb000, 128'h1), "rst_fill1");
      accept_one(1'b0, mk_req(3'd0, 8'h53, 32'hc000, 128'h2), "rst_fill0");
      @(negedge clk);
      drive_idle();
      req0_val = 1'b1; req0_msg = rc; req1_val = 1'b1; req1_msg = rd;
      memresp_val = 1'b1;
      memresp_msg = mem_answer(mk_req(3'd1, 8'h52, 32'hb000, 128'h1));
      #1;
      check("rst_mid_count", trace_count, 2'd2);
      check("rst_mid_resp1_val", resp1_val, 1'b1);
      #1;
      reset = 1'b0;
      #1;
      check("rst_async_memreq_val", memreq_val, 1'b0);
      check("rst_async_resp0_val", resp0_val, 1'b0);
      check("rst_async_resp1_val", resp1_val, 1'b0);
      check("rst_async_memresp_rdy", memresp_rdy, 1'b0);
      check("rst_async_count", trace_count, 2'd0);
      @(negedge clk);
      memresp_val = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_after_val", memreq_val, 1'b1);
      check("rst_after_msg", memreq_msg, rc);
      check("rst_after_rdy0", req0_rdy, 1'b1);
      drain_one(1'b0, mem_answer(rc), "rst_after_drain");

      // ---- randomized traffic ----
      apply_reset();
      for (int p = 0; p < 2; p++) begin
         pv[p] = 1'b0;
         pm[p] = '0;
         n_gen[p] = 0;
         n_done[p] = 0;
      end
      cyc = 0;
      while ((n_done[0] < N_TXN || n_done[1] < N_TXN) && cyc < MAX_CYC) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (!pv[p] && n_gen[p] < N_TXN && $urandom_range(0, 3) != 0) begin
               pm[p] = mk_req(3'($urandom_range(0, 1)), {p[0], 7'(n_gen[p])}, $urandom,
                              {$urandom, $urandom, $urandom, $urandom});
               pv[p] = 1'b1;
               n_gen[p]++;
            end
         end
         req0_val   = pv[0];
         req0_msg   = pm[0];
         req1_val   = pv[1];
         req1_msg   = pm[1];
         memreq_rdy = ($urandom_range(0, 3) != 0);
         resp0_rdy  = ($urandom_range(0, 3) != 0);
         resp1_rdy  = ($urandom_range(0, 3) != 0);
         memresp_val = (mem_q.size() > 0) && (mem_t[0] <= cyc);
         if (memresp_val) memresp_msg = mem_q[0];
         #1;
         acc0 = req0_val && req0_rdy;
         acc1 = req1_val && req1_rdy;
         xfer = memreq_val && memreq_rdy;
         check("rand_accept_count", 2'(acc0) + 2'(acc1), 2'(xfer));
         if (xfer && acc0) check("rand_memreq_msg0", memreq_msg, pm[0]);
         if (xfer && acc1) check("rand_memreq_msg1", memreq_msg, pm[1]);
         if (xfer) begin
            mem_q.push_back(mem_answer(memreq_msg));
            t_ready = cyc + 1 + $urandom_range(0, 5);
            if (mem_t.size() > 0 && mem_t[$] > t_ready) t_ready = mem_t[$];
            mem_t.push_back(t_ready);
         end
         if (acc0) begin
            exp_q0.push_back(mem_answer(pm[0]));
            pv[0] = 1'b0;
         end
         if (acc1) begin
            exp_q1.push_back(mem_answer(pm[1]));
            pv[1] = 1'b0;
         end
         r0 = resp0_val && resp0_rdy;
         r1 = resp1_val && resp1_rdy;
         mh = memresp_val && memresp_rdy;
         check("rand_resp_count", 2'(r0) + 2'(r1), 2'(mh));
         if (r0) begin
            if (exp_q0.size() == 0) check("rand_resp0_unexpected", r0, 1'b0);
            else begin
               check("rand_resp0_msg", resp0_msg, exp_q0.pop_front());
               n_done[0]++;
            end
         end
         if (r1) begin
            if (exp_q1.size() == 0) check("rand_resp1_unexpected", r1, 1'b0);
            else begin
               check("rand_resp1_msg", resp1_msg, exp_q1.pop_front());
               n_done[1]++;
            end
         end
         if (mh && mem_q.size() > 0) begin
            void'(mem_q.pop_front());
            void'(mem_t.pop_front());
         end
         cyc++;
      end
      check("rand_within_budget", 1'(cyc < MAX_CYC), 1'b1);
      check("rand_done0", n_done[0], N_TXN);
      check("rand_done1", n_done[1], N_TXN);
      check("rand_leftover0", exp_q0.size(), 0);
      check("rand_leftover1", exp_q1.size(), 0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares one 16B memory port between two blocking caches (port 0: instruction cache, port 1: data cache). Each cache's refill/evict requests go through round-robin arbitration with a grant lock. Responses are routed back in order using a small FIFO of requester IDs. Sits between the two cache instances and the test memory or next-level memory in the processor/cache composition.

## Interface
- p_max_outst, 2: maximum in-flight memory transactions (ID FIFO depth); power of two, ≥1
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req0_msg / req1_msg  in  mem_req_16B_t (175b)  cache memory requests
- req0_val / req1_val  in  1  request valid
- req0_rdy / req1_rdy  out  1  request ready
- resp0_msg / resp1_msg  out  mem_resp_16B_t (145b)  responses to caches
- resp0_val / resp1_val  out  1  response valid
- resp0_rdy / resp1_rdy  in  1  response ready
- memreq_msg  out  mem_req_16B_t  request to memory
- memreq_val  out  1
- memreq_rdy  in  1
- memresp_msg  in  mem_resp_16B_t  memory response; returns in request order
- memresp_val  in  1
- memresp_rdy  out  1

## Operation
- Request path:
  - grant = locked ID if lock set; otherwise round-robin among valid requesters, starting from prio_ptr.
  - memreq_msg = msg of granted requester, passed through unmodified (opaque untouched).
  - memreq_val = granted val && !fifo_full.
  - req{g}_rdy = memreq_rdy && !fifo_full; non-granted rdy = 0.
- Transfer: on memreq_val && memreq_rdy, push granted ID into ID FIFO, set prio_ptr = ~granted ID, clear lock.
- Lock: if memreq_val && !memreq_rdy, set lock = 1 and locked_id = grant. Grant then cannot switch while a request is presented, which keeps val/rdy message stability.
- Response path:
  - head = ID FIFO head.
  - resp{head}_val = memresp_val && !fifo_empty.
  - resp{head}_msg = memresp_msg; the other response val = 0, msg = memresp_msg (don't-care).
  - memresp_rdy = resp{head}_rdy && !fifo_empty.
  - On memresp_val && memresp_rdy, pop FIFO.
- FIFO full (count == p_max_outst): both req_rdy = 0, memreq_val = 0; requests stall.
- FIFO empty: memresp_rdy = 0. A response arriving then is a protocol error; assert in simulation only.
- Simultaneous push and pop on a full FIFO: not allowed, because push is gated by !fifo_full in the same cycle. Push and pop in the same cycle otherwise: count unchanged, both pointers advance.
- Pointer wrap: pointers are $clog2(p_max_outst) bits wide and wrap modulo depth. Count is one bit wider.
- Reset (asynchronous, mid-transaction included) clears everything:
  - FIFO empty, prio_ptr = 0 (port 0 favoured first), lock = 0.
  - In-flight memory responses after reset are dropped by the environment, not the block.

## Timing
- Zero-cycle request path: combinational val/rdy/msg from cache to memory; no added latency.
- Zero-cycle response path: combinational from memory to the selected cache.
- Outputs during and immediately after reset: memreq_val = 0, resp0_val = resp1_val = 0, memresp_rdy = 0. req_rdy follows memreq_rdy, since the FIFO is empty.
- Fairness: when both ports are continuously valid and memory is always ready, grants alternate every cycle: 0, 1, 0, 1…
- Lock persists across stall cycles, and clears in the cycle the transfer completes.

## Structure
- Shared package holds typedefs only: mem_req_16B_t and mem_resp_16B_t from vc/mem-msgs.v. Add no new constants there.
- One sub-module, cache_mem_arbiter_id_fifo:
  - p_depth entries of 1-bit ID, registered, asynchronous active-low reset.
  - Ports: enq_val, enq_id, deq_val, deq_id, full, empty.
- Arbitration, lock and routing live in the top module.
- Line trace: grant ID, FIFO count, and response-head ID per cycle.

## Test plan
- Single requester: req0 read at addr 0x1000, memory ready → memreq carries the identical msg in the same cycle. The memresp with data 0xdeadbeef_… reaches resp0 only; resp1_val stays 0.
- Contention: both valid every cycle, memreq_rdy = 1 → grant order 0, 1, 0, 1. With p_max_outst = 2 and memory latency 3, the FIFO fills and both rdy drop after 2 transfers.
- Stall lock: req0 valid and memreq_rdy = 0 for 3 cycles, with req1 asserted on cycle 1 → memreq_msg stays req0's for all 3 cycles. req0 transfers on cycle 4, then req1 is granted on cycle 5.
- In-order return: req1 write then req0 read accepted back-to-back → first memresp goes to resp1 and second to resp0. Hold resp1_rdy = 0 for 2 cycles → memresp_rdy = 0 for those cycles and no pop occurs.
- Reset mid-flight: 2 transactions outstanding, assert reset low asynchronously between edges → memreq_val, resp*_val and memresp_rdy fall to 0 immediately. After release, the first grant goes to port 0.
- Random: random val/rdy and memory delays 0–5 over 1000 transactions per port → each cache receives exactly its own responses, in issue order.
